// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard-unit and interrupt-sequencer state encodings
// plus the default interrupt vector address.
package pipeline_pkg;

   typedef enum logic [1:0] {
      HZ_NONE  = 2'd0,
      HZ_STALL = 2'd1,
      HZ_FLUSH = 2'd2
   } hazard_state_e;

   typedef enum logic [2:0] {
      INT_IDLE   = 3'd0,
      INT_DRAIN  = 3'd1,
      INT_FLUSH  = 3'd2,
      INT_VECTOR = 3'd3,
      INT_ISR    = 3'd4,
      INT_RETURN = 3'd5
   } int_state_e;

   localparam logic [9:0]  INT_VECTOR_ADDR_DEFAULT = 10'h3FF;
   localparam int unsigned INT_FLUSH_CNT_W         = 3;

endpackage

// File: rtl/interrupt_sequencer.sv
// Interrupt entry/exit sequencer: drains the fetch pipe, injects decode nops,
// vectors the PC to the handler and restores it on RETI.
module interrupt_sequencer
   import pipeline_pkg::*;
#(
   parameter int unsigned         PC_WIDTH     = 10,
   parameter logic [PC_WIDTH-1:0] VECTOR_ADDR  = PC_WIDTH'(INT_VECTOR_ADDR_DEFAULT),
   parameter int unsigned         FLUSH_CYCLES = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                int_req,
   input  logic                int_en,
   input  logic                pc_stall,
   input  logic                branch_flush,
   input  logic                reti_ex,
   input  logic [PC_WIDTH-1:0] fetch_pc,
   output logic                pc_load,
   output logic [PC_WIDTH-1:0] pc_target,
   output logic                fetch_hold,
   output logic                dec_nop,
   output logic                int_ack,
   output logic                int_en_clr,
   output logic                int_en_set,
   output logic                busy
);

   localparam logic [INT_FLUSH_CNT_W-1:0] FLUSH_LOAD = INT_FLUSH_CNT_W'(FLUSH_CYCLES);

   int_state_e                 state_q, state_d;
   logic                       pending_q, pending_d;
   logic                       req_prev_q, req_prev_d;
   logic [INT_FLUSH_CNT_W-1:0] cnt_q, cnt_d;
   logic [PC_WIDTH-1:0]        resume_pc_q, resume_pc_d;
   logic                       req_rose;

   assign req_rose   = int_req & ~req_prev_q;
   assign req_prev_d = int_req;

   // A new request edge wins over the VECTOR-cycle clear so no interrupt is lost.
   assign pending_d = (pending_q & (state_q != INT_VECTOR)) | req_rose;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      resume_pc_d = resume_pc_q;
      case (state_q)
         INT_IDLE: begin
            if (pending_q && int_en) state_d = INT_DRAIN;
         end
         INT_DRAIN: begin
            if (!pc_stall && !branch_flush) begin
               resume_pc_d = fetch_pc;
               cnt_d       = FLUSH_LOAD;
               state_d     = INT_FLUSH;
            end
         end
         INT_FLUSH: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == 1) state_d = INT_VECTOR;
         end
         INT_VECTOR: state_d = INT_ISR;
         INT_ISR: begin
            if (reti_ex) state_d = INT_RETURN;
         end
         INT_RETURN: state_d = INT_IDLE;
         default:    state_d = INT_IDLE;
      endcase
   end

   always_comb begin
      pc_load    = 1'b0;
      pc_target  = resume_pc_q;
      fetch_hold = 1'b0;
      dec_nop    = 1'b0;
      int_ack    = 1'b0;
      int_en_clr = 1'b0;
      int_en_set = 1'b0;
      busy       = (state_q != INT_IDLE);
      case (state_q)
         INT_DRAIN: fetch_hold = 1'b1;
         INT_FLUSH: begin
            fetch_hold = 1'b1;
            dec_nop    = 1'b1;
         end
         INT_VECTOR: begin
            pc_load    = 1'b1;
            pc_target  = VECTOR_ADDR;
            dec_nop    = 1'b1;
            int_ack    = 1'b1;
            int_en_clr = 1'b1;
         end
         INT_RETURN: begin
            pc_load    = 1'b1;
            dec_nop    = 1'b1;
            int_en_set = 1'b1;
         end
         default: ;
      endcase
   end

   // Clearing req_prev on reset makes a request held high across reset count as an edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= INT_IDLE;
         pending_q   <= 1'b0;
         req_prev_q  <= 1'b0;
         cnt_q       <= '0;
         resume_pc_q <= '0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         req_prev_q  <= req_prev_d;
         cnt_q       <= cnt_d;
         resume_pc_q <= resume_pc_d;
      end
   end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer: directed scenarios plus randomized
// traffic compared against a phase-level reference model.
module tb_interrupt_sequencer;

   localparam logic [9:0] VEC   = 10'h3FF;
   localparam int         FLUSH = 2;

   // Expected {pc_load, fetch_hold, dec_nop, int_ack, int_en_clr, int_en_set, busy}
   localparam logic [6:0] C_IDLE  = 7'b0000000;
   localparam logic [6:0] C_DRAIN = 7'b0100001;
   localparam logic [6:0] C_FLUSH = 7'b0110001;
   localparam logic [6:0] C_VEC   = 7'b1011101;
   localparam logic [6:0] C_ISR   = 7'b0000001;
   localparam logic [6:0] C_RET   = 7'b1010011;

   localparam int P_IDLE = 0, P_DRAIN = 1, P_FLUSH = 2, P_VEC = 3, P_ISR = 4, P_RET = 5;

   logic       clk = 1'b0;
   logic       reset_n, int_req, int_en, pc_stall, branch_flush, reti_ex;
   logic [9:0] fetch_pc;
   logic       pc_load, fetch_hold, dec_nop, int_ack, int_en_clr, int_en_set, busy;
   logic [9:0] pc_target;
   logic [6:0] ctl;

   int n_vec  = 0;
   int n_fail = 0;

   // Reference model state
   int         m_phase;
   int         m_left;
   bit         m_pend;
   bit         m_prev;
   logic [9:0] m_resume;

   assign ctl = {pc_load, fetch_hold, dec_nop, int_ack, int_en_clr, int_en_set, busy};

   interrupt_sequencer dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .int_req      (int_req),
      .int_en       (int_en),
      .pc_stall     (pc_stall),
      .branch_flush (branch_flush),
      .reti_ex      (reti_ex),
      .fetch_pc     (fetch_pc),
      .pc_load      (pc_load),
      .pc_target    (pc_target),
      .fetch_hold   (fetch_hold),
      .dec_nop      (dec_nop),
      .int_ack      (int_ack),
      .int_en_clr   (int_en_clr),
      .int_en_set   (int_en_set),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time bound expired before summary");
      $fatal(1, "watchdog expired");
   end

   function automatic void model_reset();
      m_phase  = P_IDLE;
      m_left   = 0;
      m_pend   = 1'b0;
      m_prev   = 1'b0;
      m_resume = '0;
   endfunction

   // One clock of the interrupt protocol, driven from the current input values.
   function automatic void model_step();
      bit rose;
      int nxt;
      rose = int_req && !m_prev;
      nxt  = m_phase;
      case (m_phase)
         P_IDLE:  if (m_pend && int_en) nxt = P_DRAIN;
         P_DRAIN: if (!pc_stall && !branch_flush) begin
            m_resume = fetch_pc;
            m_left   = FLUSH;
            nxt      = P_FLUSH;
         end
         P_FLUSH: begin
            m_left = m_left - 1;
            if (m_left == 0) nxt = P_VEC;
         end
         P_VEC:   nxt = P_ISR;
         P_ISR:   if (reti_ex) nxt = P_RET;
         default: nxt = P_IDLE;
      endcase
      if (m_phase == P_VEC) m_pend = 1'b0;
      if (rose) m_pend = 1'b1;
      m_prev  = int_req;
      m_phase = nxt;
   endfunction

   function automatic logic [6:0] exp_ctl(int ph);
      case (ph)
         P_DRAIN: return C_DRAIN;
         P_FLUSH: return C_FLUSH;
         P_VEC:   return C_VEC;
         P_ISR:   return C_ISR;
         P_RET:   return C_RET;
         default: return C_IDLE;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      if (!reset_n) model_reset();
      else model_step();
      @(negedge clk);
   endtask

   task automatic apply_reset();
      reset_n = 1'b0; int_req = 1'b0; int_en = 1'b0; pc_stall = 1'b0;
      branch_flush = 1'b0; reti_ex = 1'b0; fetch_pc = '0;
      model_reset();
      repeat (2) tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; int_req = 1'b1; int_en = 1'b1; pc_stall = 1'b0;
      branch_flush = 1'b0; reti_ex = 1'b1; fetch_pc = 10'h155;
      model_reset();
      tick();
      n_vec++; if (ctl !== C_IDLE) begin n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl, C_IDLE); end
      n_vec++; if (pc_target !== 10'h000) begin n_fail++; $display("FAIL reset_target: got %h want 000", pc_target); end
      int_req = 1'b0; reti_ex = 1'b0;
      tick();
      reset_n = 1'b1;
      repeat (3) tick();
      n_vec++; if (ctl !== C_IDLE) begin n_fail++; $display("FAIL reset_release_idle: got %b want %b", ctl, C_IDLE); end
   endtask

   task automatic test_basic();
      apply_reset();
      int_en = 1'b1; fetch_pc = 10'h042; reti_ex = 1'b1;
      tick();
      n_vec++; if (ctl !== C_IDLE) begin n_fail++; $display("FAIL basic_reti_ignored: got %b want %b", ctl, C_IDLE); end
      reti_ex = 1'b0; int_req = 1'b1;
      tick();
      n_vec++; if (ctl !== C_IDLE) begin n_fail++; $display("FAIL basic_accept: got %b want %b", ctl, C_IDLE); end
      for (int i = 1; i <= 3; i++) begin
         tick();
         n_vec++;
         if (ctl !== ((i == 1) ? C_DRAIN : C_FLUSH)) begin
            n_fail++; $display("FAIL basic_pre_vector%0d: got %b want %b", i, ctl, (i == 1) ? C_DRAIN : C_FLUSH);
         end
      end
      tick();
      n_vec++; if (ctl !== C_VEC) begin n_fail++; $display("FAIL basic_vector: got %b want %b", ctl, C_VEC); end
      n_vec++; if (pc_target !== VEC) begin n_fail++; $display("FAIL basic_vector_target: got %h want %h", pc_target, VEC); end
      int_req = 1'b0;
      tick();
      n_vec++; if (ctl !== C_ISR) begin n_fail++; $display("FAIL basic_isr: got %b want %b", ctl, C_ISR); end
      n_vec++; if (pc_target !== 10'h042) begin n_fail++; $display("FAIL basic_isr_target: got %h want 042", pc_target); end
      tick();
      reti_ex = 1'b1;
      tick();
      n_vec++; if (ctl !== C_RET) begin n_fail++; $display("FAIL basic_return: got %b want %b", ctl, C_RET); end
      n_vec++; if (pc_target !== 10'h042) begin n_fail++; $display("FAIL basic_return_target: got %h want 042", pc_target); end
      reti_ex = 1'b0;
      tick();
      n_vec++; if (ctl !== C_IDLE) begin n_fail++; $display("FAIL basic_back_idle: got %b want %b", ctl, C_IDLE); end
   endtask

   task automatic test_drain_stall();
      apply_reset();
      int_en = 1'b1; pc_stall = 1'b1; fetch_pc = 10'h100;
      tick();
      int_req = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         tick();
         fetch_pc = 10'h101 + 10'(i);
         if (i == 2) begin pc_stall = 1'b0; branch_flush = 1'b1; end
         n_vec++; if (ctl !== C_DRAIN) begin n_fail++; $display("FAIL stall_drain%0d: got %b want %b", i, ctl, C_DRAIN); end
      end
      branch_flush = 1'b0; fetch_pc = 10'h155;
      tick();
      fetch_pc = 10'h2AA;
      n_vec++; if (ctl !== C_FLUSH) begin n_fail++; $display("FAIL stall_flush: got %b want %b", ctl, C_FLUSH); end
      repeat (2) tick();
      n_vec++; if (ctl !== C_VEC) begin n_fail++; $display("FAIL stall_vector: got %b want %b", ctl, C_VEC); end
      tick();
      n_vec++; if (pc_target !== 10'h155) begin n_fail++; $display("FAIL stall_resume_pc: got %h want 155", pc_target); end
      reti_ex = 1'b1;
      tick();
      n_vec++; if (ctl !== C_RET || pc_target !== 10'h155) begin
         n_fail++; $display("FAIL stall_return: got %b/%h want %b/155", ctl, pc_target, C_RET);
      end
      reti_ex = 1'b0; int_req = 1'b0;
      tick();
   endtask

   task automatic test_deferred_enable();
      apply_reset();
      tick();
      int_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_vec++; if (ctl !== C_IDLE) begin n_fail++; $display("FAIL defer_wait%0d: got %b want %b", i, ctl, C_IDLE); end
      end
      int_en = 1'b1;
      tick();
      n_vec++; if (ctl !== C_DRAIN) begin n_fail++; $display("FAIL defer_drain: got %b want %b", ctl, C_DRAIN); end
      int_en = 1'b0;
      repeat (3) tick();
      n_vec++; if (ctl !== C_VEC) begin n_fail++; $display("FAIL defer_no_abort: got %b want %b", ctl, C_VEC); end
      tick();
      reti_ex = 1'b1;
      tick();
      reti_ex = 1'b0;
      repeat (3) tick();
      n_vec++; if (ctl !== C_IDLE) begin n_fail++; $display("FAIL defer_no_retrigger: got %b want %b", ctl, C_IDLE); end
   endtask

   task automatic test_reset_mid_flush();
      apply_reset();
      int_en = 1'b1; fetch_pc = 10'h0F0;
      tick();
      int_req = 1'b1;
      repeat (3) tick();
      n_vec++; if (ctl !== C_FLUSH) begin n_fail++; $display("FAIL rstflush_in_flush: got %b want %b", ctl, C_FLUSH); end
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      n_vec++; if (ctl !== C_IDLE || pc_target !== 10'h000) begin
         n_fail++; $display("FAIL rstflush_immediate: got %b/%h want %b/000", ctl, pc_target, C_IDLE);
      end
      int_req = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         n_vec++; if (ctl !== C_IDLE) begin n_fail++; $display("FAIL rstflush_quiet%0d: got %b want %b", i, ctl, C_IDLE); end
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      int_en = 1'b1; fetch_pc = 10'h0A5;
      tick();
      int_req = 1'b1;
      tick();
      repeat (3) tick();
      tick();
      n_vec++; if (ctl !== C_VEC) begin n_fail++; $display("FAIL b2b_vector1: got %b want %b", ctl, C_VEC); end
      int_req = 1'b0;
      tick();
      int_req = 1'b1;
      tick();
      tick();
      n_vec++; if (ctl !== C_ISR) begin n_fail++; $display("FAIL b2b_isr_hold: got %b want %b", ctl, C_ISR); end
      reti_ex = 1'b1;
      tick();
      n_vec++; if (ctl !== C_RET || pc_target !== 10'h0A5) begin
         n_fail++; $display("FAIL b2b_return: got %b/%h want %b/0a5", ctl, pc_target, C_RET);
      end
      reti_ex = 1'b0;
      tick();
      n_vec++; if (ctl !== C_IDLE) begin n_fail++; $display("FAIL b2b_idle_gap: got %b want %b", ctl, C_IDLE); end
      tick();
      n_vec++; if (ctl !== C_DRAIN) begin n_fail++; $display("FAIL b2b_drain2: got %b want %b", ctl, C_DRAIN); end
      repeat (2) tick();
      tick();
      n_vec++; if (ctl !== C_VEC) begin n_fail++; $display("FAIL b2b_vector2: got %b want %b", ctl, C_VEC); end
   endtask

   task automatic test_reset_edge();
      reset_n = 1'b0; int_req = 1'b1; int_en = 1'b1; pc_stall = 1'b0;
      branch_flush = 1'b0; reti_ex = 1'b0;
      model_reset();
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
      n_vec++; if (ctl !== C_IDLE) begin n_fail++; $display("FAIL rstedge_accept: got %b want %b", ctl, C_IDLE); end
      tick();
      n_vec++; if (ctl !== C_DRAIN) begin n_fail++; $display("FAIL rstedge_drain: got %b want %b", ctl, C_DRAIN); end
   endtask

   task automatic test_random();
      apply_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(7) == 0) int_req = ~int_req;
         int_en       = ($urandom_range(3) != 0);
         pc_stall     = ($urandom_range(3) == 0);
         branch_flush = ($urandom_range(7) == 0);
         reti_ex      = ($urandom_range(5) == 0);
         fetch_pc     = 10'($urandom);
         reset_n      = ($urandom_range(249) != 0);
         tick();
         n_vec++;
         if (ctl !== exp_ctl(m_phase) || pc_target !== ((m_phase == P_VEC) ? VEC : m_resume)) begin
            n_fail++;
            $display("FAIL random%0d: got %b/%h want %b/%h", i, ctl, pc_target,
                     exp_ctl(m_phase), (m_phase == P_VEC) ? VEC : m_resume);
         end
      end
      reset_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_drain_stall();
      test_deferred_enable();
      test_reset_mid_flush();
      test_back_to_back();
      test_reset_edge();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
